// File: rtl/lvds_pkg.sv
// rtl/lvds_pkg.sv - shared types and constants for the LVDS frame aligner
package lvds_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CHECK,
        ST_SLIP,
        ST_SETTLE,
        ST_VERIFY,
        ST_LOCK,
        ST_FAIL
    } align_state_t;

    localparam int DEFAULT_DATA_WIDTH = 10;
    localparam logic [DEFAULT_DATA_WIDTH-1:0] DEFAULT_FRAME_PATTERN = 10'b1111100000;
    localparam int DEFAULT_SLIP_CNT_W = $clog2(2 * DEFAULT_DATA_WIDTH + 1);

    // Width of a counter that must hold values 0..max_val inclusive.
    function automatic int cnt_width(input int max_val);
        return (max_val < 1) ? 1 : $clog2(max_val + 1);
    endfunction

endpackage

// File: rtl/lvds_word_reorder.sv
// rtl/lvds_word_reorder.sv - optional bit reversal of one deserialized word
module lvds_word_reorder #(
    parameter int DATA_WIDTH = 10,
    parameter bit REVERSE    = 1'b0
) (
    input  logic [DATA_WIDTH-1:0] word,
    output logic [DATA_WIDTH-1:0] reordered
);

    always_comb begin
        reordered = word;
        if (REVERSE) begin
            for (int b = 0; b < DATA_WIDTH; b++) begin
                reordered[b] = word[DATA_WIDTH-1-b];
            end
        end
    end

endmodule

// File: rtl/lvds_frame_aligner.sv
// rtl/lvds_frame_aligner.sv - bitslip search on the frame lane, lock tracking and word output
module lvds_frame_aligner
    import lvds_pkg::*;
#(
    parameter int                    DATA_WIDTH    = 10,
    parameter int                    NUM_CH        = 4,
    parameter logic [DATA_WIDTH-1:0] FRAME_PATTERN = DEFAULT_FRAME_PATTERN,
    parameter int                    SETTLE_CYCLES = 4,
    parameter int                    MATCH_COUNT   = 8,
    parameter int                    LOSS_COUNT    = 4,
    parameter int                    MAX_SLIPS     = 2 * DATA_WIDTH,
    parameter bit                    MSB_FIRST     = 1'b0
) (
    input  logic                           CLKDIV,
    input  logic                           RST_N,
    input  logic                           EN,
    input  logic [DATA_WIDTH-1:0]          FRAME_Q,
    input  logic [NUM_CH*DATA_WIDTH-1:0]   DATA_Q,
    output logic                           BITSLIP,
    output logic [NUM_CH*DATA_WIDTH-1:0]   DATA_OUT,
    output logic                           DATA_VALID,
    output logic                           LOCKED,
    output logic                           ALIGN_ERR,
    output logic [$clog2(MAX_SLIPS+1)-1:0] SLIP_CNT
);

    localparam int SCW = cnt_width(MAX_SLIPS);
    localparam int MCW = cnt_width(MATCH_COUNT);
    localparam int LCW = cnt_width(LOSS_COUNT);
    localparam int TCW = cnt_width(SETTLE_CYCLES);

    localparam logic [SCW-1:0] SLIP_MAX     = SCW'(MAX_SLIPS);
    localparam logic [MCW-1:0] MATCH_TARGET = MCW'(MATCH_COUNT);
    localparam logic [LCW-1:0] LOSS_LAST    = LCW'(LOSS_COUNT - 1);
    localparam logic [TCW-1:0] SETTLE_LAST  = TCW'(SETTLE_CYCLES - 1);

    align_state_t   state;
    logic [MCW-1:0] match_cnt;
    logic [MCW-1:0] next_match;
    logic [LCW-1:0] loss_cnt;
    logic [TCW-1:0] settle_cnt;
    logic           match;

    logic [NUM_CH*DATA_WIDTH-1:0] reordered;

    assign match = (FRAME_Q == FRAME_PATTERN);

    // CHECK starts a fresh run of matches; VERIFY extends the current one.
    assign next_match = (state == ST_CHECK) ? MCW'(1) : match_cnt + MCW'(1);

    always_ff @(posedge CLKDIV or negedge RST_N) begin
        if (!RST_N) begin
            state      <= ST_IDLE;
            BITSLIP    <= 1'b0;
            LOCKED     <= 1'b0;
            ALIGN_ERR  <= 1'b0;
            SLIP_CNT   <= '0;
            match_cnt  <= '0;
            loss_cnt   <= '0;
            settle_cnt <= '0;
        end else if (!EN) begin
            state      <= ST_IDLE;
            BITSLIP    <= 1'b0;
            LOCKED     <= 1'b0;
            ALIGN_ERR  <= 1'b0;
            SLIP_CNT   <= '0;
            match_cnt  <= '0;
            loss_cnt   <= '0;
            settle_cnt <= '0;
        end else begin
            BITSLIP <= 1'b0;
            case (state)
                ST_IDLE: begin
                    state    <= ST_CHECK;
                    SLIP_CNT <= '0;
                end
                ST_CHECK, ST_VERIFY: begin
                    if (match) begin
                        match_cnt <= next_match;
                        if (next_match == MATCH_TARGET) begin
                            state    <= ST_LOCK;
                            LOCKED   <= 1'b1;
                            loss_cnt <= '0;
                        end else begin
                            state <= ST_VERIFY;
                        end
                    end else if (SLIP_CNT == SLIP_MAX) begin
                        state     <= ST_FAIL;
                        ALIGN_ERR <= 1'b1;
                    end else begin
                        // Counter only advances below the limit, so it saturates.
                        state    <= ST_SLIP;
                        BITSLIP  <= 1'b1;
                        SLIP_CNT <= SLIP_CNT + SCW'(1);
                    end
                end
                ST_SLIP: begin
                    state      <= ST_SETTLE;
                    settle_cnt <= '0;
                end
                ST_SETTLE: begin
                    if (settle_cnt == SETTLE_LAST) begin
                        state <= ST_CHECK;
                    end else begin
                        settle_cnt <= settle_cnt + TCW'(1);
                    end
                end
                ST_LOCK: begin
                    if (match) begin
                        loss_cnt <= '0;
                    end else if (loss_cnt == LOSS_LAST) begin
                        state    <= ST_CHECK;
                        LOCKED   <= 1'b0;
                        SLIP_CNT <= '0;
                        loss_cnt <= '0;
                    end else begin
                        loss_cnt <= loss_cnt + LCW'(1);
                    end
                end
                ST_FAIL: begin
                    LOCKED <= 1'b0;
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

    for (genvar ch = 0; ch < NUM_CH; ch++) begin : g_reorder
        lvds_word_reorder #(
            .DATA_WIDTH(DATA_WIDTH),
            .REVERSE   (MSB_FIRST)
        ) u_reorder (
            .word     (DATA_Q[ch*DATA_WIDTH +: DATA_WIDTH]),
            .reordered(reordered[ch*DATA_WIDTH +: DATA_WIDTH])
        );
    end

    always_ff @(posedge CLKDIV or negedge RST_N) begin
        if (!RST_N) begin
            DATA_OUT   <= '0;
            DATA_VALID <= 1'b0;
        end else begin
            DATA_OUT   <= reordered;
            DATA_VALID <= (state == ST_LOCK);
        end
    end

endmodule

// File: tb/tb_lvds_frame_aligner.sv
// tb/tb_lvds_frame_aligner.sv - directed bench for the LVDS frame aligner
module tb_lvds_frame_aligner;

    localparam int DW = 10;
    localparam int NC = 4;
    localparam logic [DW-1:0] PATTERN = 10'h3E0;

    logic           clk = 1'b0;
    logic           rst_n = 1'b0;
    logic           en = 1'b0;
    logic [DW-1:0]  frame_q;
    logic [NC*DW-1:0] data_q = '0;

    logic           bitslip, bitslip_r;
    logic [NC*DW-1:0] data_out, data_out_r;
    logic           data_valid, data_valid_r;
    logic           locked, locked_r;
    logic           align_err, align_err_r;
    logic [4:0]     slip_cnt, slip_cnt_r;

    int  rot = 0;
    bit  stuck = 1'b0;
    bit  corrupt = 1'b0;
    int  pend = 0;
    int  cyc = 0;
    int  pulses = 0;
    int  last_pulse = -1;
    int  min_gap = 1000;
    int  errors = 0;
    int  checks = 0;

    always #5 clk = ~clk;

    function automatic logic [DW-1:0] rotl(input logic [DW-1:0] w, input int k);
        logic [DW-1:0] r;
        r = w;
        for (int i = 0; i < k; i++) r = {r[DW-2:0], r[DW-1]};
        return r;
    endfunction

    assign frame_q = stuck ? '0 : (rotl(PATTERN, rot) ^ (corrupt ? 10'h001 : 10'h000));

    lvds_frame_aligner #(.MSB_FIRST(1'b0)) dut (
        .CLKDIV(clk), .RST_N(rst_n), .EN(en), .FRAME_Q(frame_q), .DATA_Q(data_q),
        .BITSLIP(bitslip), .DATA_OUT(data_out), .DATA_VALID(data_valid),
        .LOCKED(locked), .ALIGN_ERR(align_err), .SLIP_CNT(slip_cnt)
    );

    lvds_frame_aligner #(.MSB_FIRST(1'b1)) dut_rev (
        .CLKDIV(clk), .RST_N(rst_n), .EN(en), .FRAME_Q(frame_q), .DATA_Q(data_q),
        .BITSLIP(bitslip_r), .DATA_OUT(data_out_r), .DATA_VALID(data_valid_r),
        .LOCKED(locked_r), .ALIGN_ERR(align_err_r), .SLIP_CNT(slip_cnt_r)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // One clock; the deserializer model rotates the frame word 2 cycles after a slip pulse.
    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
        if (pend > 0) begin
            pend--;
            if (pend == 0) rot = (rot + DW - 1) % DW;
        end
        if (bitslip) begin
            pulses++;
            if (last_pulse >= 0 && (cyc - last_pulse) < min_gap) min_gap = cyc - last_pulse;
            last_pulse = cyc;
            pend = 2;
        end
    endtask

    task automatic clear_pulse_stats();
        pulses = 0;
        last_pulse = -1;
        min_gap = 1000;
    endtask

    initial begin
        int n;

        // Reset state
        tick();
        tick();
        check("rst_bitslip", bitslip, 0);
        check("rst_locked", locked, 0);
        check("rst_valid", data_valid, 0);
        check("rst_err", align_err, 0);
        check("rst_slipcnt", slip_cnt, 0);
        check("rst_dout", data_out, 0);
        rst_n = 1'b1;
        tick();

        // Already aligned: lock 8 cycles after CHECK entry, no slips
        clear_pulse_stats();
        rot = 0;
        en = 1'b1;
        for (int i = 0; i < 8; i++) tick();
        check("aligned_not_yet", locked, 0);
        tick();
        check("aligned_locked", locked, 1);
        check("aligned_pulses", pulses, 0);
        check("aligned_slipcnt", slip_cnt, 0);

        // Data path, normal and reversed
        data_q = {10'h001, 10'h3FF, 10'h0F3, 10'h155};
        tick();
        check("dout", data_out, {10'h001, 10'h3FF, 10'h0F3, 10'h155});
        check("dout_ch0", data_out[9:0], 10'h155);
        check("dvalid", data_valid, 1);
        check("dout_rev", data_out_r, {10'h200, 10'h3FF, 10'h33C, 10'h2AA});
        check("dvalid_rev", data_valid_r, 1);

        // Three corrupt frames are tolerated
        corrupt = 1'b1;
        for (int i = 0; i < 3; i++) tick();
        corrupt = 1'b0;
        tick();
        check("loss3_locked", locked, 1);
        tick();

        // Four corrupt frames drop lock and restart the search
        corrupt = 1'b1;
        for (int i = 0; i < 3; i++) tick();
        check("loss4_pre", locked, 1);
        tick();
        check("loss4_locked", locked, 0);
        check("loss4_slipcnt", slip_cnt, 0);
        corrupt = 1'b0;
        tick();
        check("loss4_valid", data_valid, 0);
        for (int i = 0; i < 7; i++) tick();
        check("relock", locked, 1);

        // Initial rotation 3: exactly three slips
        en = 1'b0;
        tick();
        check("en_low_locked", locked, 0);
        rot = 3;
        clear_pulse_stats();
        en = 1'b1;
        n = 0;
        while (!locked && n < 300) begin
            tick();
            n++;
        end
        check("rot3_locked", locked, 1);
        check("rot3_pulses", pulses, 3);
        check("rot3_gap_ok", min_gap >= 6, 1);
        check("rot3_slipcnt", slip_cnt, 3);
        check("rot3_err", align_err, 0);

        // Frame lane stuck low: exhaust the search
        en = 1'b0;
        tick();
        stuck = 1'b1;
        clear_pulse_stats();
        en = 1'b1;
        n = 0;
        while (!align_err && n < 400) begin
            tick();
            n++;
        end
        for (int i = 0; i < 10; i++) tick();
        check("stuck_err", align_err, 1);
        check("stuck_pulses", pulses, 20);
        check("stuck_gap_ok", min_gap >= 6, 1);
        check("stuck_locked", locked, 0);
        check("stuck_slipcnt", slip_cnt, 20);
        en = 1'b0;
        tick();
        check("stuck_clr_err", align_err, 0);
        check("stuck_clr_slipcnt", slip_cnt, 0);

        // Asynchronous reset in the middle of a slip pulse
        stuck = 1'b0;
        rot = 2;
        en = 1'b1;
        n = 0;
        while (!bitslip && n < 50) begin
            tick();
            n++;
        end
        check("arst_pulse_seen", bitslip, 1);
        check("arst_pre_slipcnt", slip_cnt, 1);
        rst_n = 1'b0;
        #1;
        check("arst_bitslip", bitslip, 0);
        check("arst_locked", locked, 0);
        check("arst_valid", data_valid, 0);
        check("arst_slipcnt", slip_cnt, 0);
        check("arst_dout", data_out, 0);
        tick();
        rst_n = 1'b1;
        tick();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
